// File: rtl/sdram_pkg.sv
// ============================================================================
// Module      : sdram_pkg
// Description : Shared types for the SDRAM port arbiter: FSM states, port id
//               and the registered request bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    typedef struct packed {
        logic [24:0] addr;
        logic [15:0] din;
        logic        word;
        logic        we;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/sdram_port_arbiter_if.sv
// ============================================================================
// Module      : sdram_port_arbiter_if
// Description : Client ports A/B plus the controller-side rd/wr/busy bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_port_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic        a_word;
    logic [24:0] a_addr;
    logic [15:0] a_din;
    logic        a_ack;
    logic [15:0] a_dout;

    logic        b_req;
    logic        b_we;
    logic        b_word;
    logic [24:0] b_addr;
    logic [15:0] b_din;
    logic        b_ack;
    logic [15:0] b_dout;

    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_word;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_dout;
    logic        mem_busy;

    // Clients and the controller together form the master side.
    modport master (
        output a_req, a_we, a_word, a_addr, a_din,
        input  a_ack, a_dout,
        output b_req, b_we, b_word, b_addr, b_din,
        input  b_ack, b_dout,
        input  mem_addr, mem_din, mem_word, mem_rd, mem_wr,
        output mem_dout, mem_busy
    );

    modport slave (
        input  a_req, a_we, a_word, a_addr, a_din,
        output a_ack, a_dout,
        input  b_req, b_we, b_word, b_addr, b_din,
        output b_ack, b_dout,
        output mem_addr, mem_din, mem_word, mem_rd, mem_wr,
        input  mem_dout, mem_busy
    );
endinterface

`default_nettype wire

// File: rtl/sdram_grant.sv
// ============================================================================
// Module      : sdram_grant
// Description : Fixed-priority / round-robin port select with its pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_grant
    import sdram_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  wire           clk,
    input  wire           reset_n,
    input  wire           i_a_req,
    input  wire           i_b_req,
    input  wire mem_req_t i_a_cmd,
    input  wire mem_req_t i_b_cmd,
    input  wire           i_take,
    output logic          o_req_any,
    output port_id_e      o_grant_id,
    output mem_req_t      o_grant_cmd
);

    // Set when B should win the next contested grant.
    logic r_prio_b;

    always_comb begin
        o_grant_id = PORT_A;
        if (i_a_req && i_b_req) begin
            o_grant_id = (ROUND_ROBIN && r_prio_b) ? PORT_B : PORT_A;
        end else if (i_b_req) begin
            o_grant_id = PORT_B;
        end
        o_grant_cmd = (o_grant_id == PORT_B) ? i_b_cmd : i_a_cmd;
    end

    assign o_req_any = i_a_req | i_b_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio_b <= 1'b0;
        end else if (i_take && ROUND_ROBIN) begin
            r_prio_b <= (o_grant_id == PORT_A);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Serialises two client ports onto the edge-triggered SDRAM
//               controller rd/wr + busy interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  wire              clk,
    input  wire              reset_n,
    sdram_port_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_ISSUE     = ISSUE;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;
    localparam logic [1:0] ST_GAP       = GAP;

    mem_req_t    w_a_cmd;
    mem_req_t    w_b_cmd;
    mem_req_t    w_grant_cmd;
    port_id_e    w_grant_id;
    logic        w_req_any;
    logic        w_take;

    logic [1:0]  r_state;
    port_id_e    r_port;
    logic        r_we;
    logic [24:0] r_mem_addr;
    logic [15:0] r_mem_din;
    logic        r_mem_word;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_a_ack;
    logic        r_b_ack;
    logic [15:0] r_a_dout;
    logic [15:0] r_b_dout;

    assign w_a_cmd = '{addr: bus.a_addr, din: bus.a_din, word: bus.a_word, we: bus.a_we};
    assign w_b_cmd = '{addr: bus.b_addr, din: bus.b_din, word: bus.b_word, we: bus.b_we};
    assign w_take  = (r_state == ST_IDLE) && w_req_any;

    sdram_grant #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_grant (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_a_req     (bus.a_req),
        .i_b_req     (bus.b_req),
        .i_a_cmd     (w_a_cmd),
        .i_b_cmd     (w_b_cmd),
        .i_take      (w_take),
        .o_req_any   (w_req_any),
        .o_grant_id  (w_grant_id),
        .o_grant_cmd (w_grant_cmd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_port     <= PORT_A;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_word <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_a_dout   <= '0;
            r_b_dout   <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_mem_addr <= w_grant_cmd.addr;
                        r_mem_din  <= w_grant_cmd.din;
                        r_mem_word <= w_grant_cmd.word;
                        r_we       <= w_grant_cmd.we;
                        r_port     <= w_grant_id;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_rd <= ~r_we;
                    r_mem_wr <= r_we;
                    // Only trust busy once our own edge is on the bus.
                    if ((r_mem_rd || r_mem_wr) && bus.mem_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.mem_busy) begin
                        if (!r_we) begin
                            if (r_port == PORT_B) r_b_dout <= bus.mem_dout;
                            else                  r_a_dout <= bus.mem_dout;
                        end
                        r_a_ack  <= (r_port == PORT_A);
                        r_b_ack  <= (r_port == PORT_B);
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.mem_word = r_mem_word;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_wr   = r_mem_wr;
    assign bus.a_ack    = r_a_ack;
    assign bus.b_ack    = r_b_ack;
    assign bus.a_dout   = r_a_dout;
    assign bus.b_dout   = r_b_dout;

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Directed bench: fixed-priority and round-robin arbiters, each
//               driving a small edge-triggered SDRAM controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_port_arbiter;

    localparam int C_BUSY = 5;

    logic clk;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    sdram_port_arbiter_if if0 ();
    sdram_port_arbiter_if if1 ();

    sdram_port_arbiter #(.ROUND_ROBIN(1'b0)) u_dut_fixed (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0.slave)
    );

    sdram_port_arbiter #(.ROUND_ROBIN(1'b1)) u_dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: accept a high rd/wr level once, hold busy C_BUSY
    // cycles, return f(addr), then wait for the level to drop.
    logic [1:0]  m_busy  = 2'b00;
    logic [1:0]  m_stall = 2'b00;
    logic [15:0] m_dout [2];
    int          m_st   [2];
    int          m_cnt  [2];
    int          m_low  [2];
    int          m_gap  [2];
    wire  [1:0]  m_lvl;
    wire  [24:0] m_addr [2];

    assign m_lvl[0]     = if0.mem_rd | if0.mem_wr;
    assign m_lvl[1]     = if1.mem_rd | if1.mem_wr;
    assign m_addr[0]    = if0.mem_addr;
    assign m_addr[1]    = if1.mem_addr;
    assign if0.mem_busy = m_busy[0];
    assign if1.mem_busy = m_busy[1];
    assign if0.mem_dout = m_dout[0];
    assign if1.mem_dout = m_dout[1];

    function automatic logic [15:0] rdata(input logic [24:0] a);
        return (a == 25'h100) ? 16'hBEEF : (a[15:0] ^ 16'hC3C3);
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = '0; m_st[i] = 0; m_cnt[i] = 0; m_low[i] = 0; m_gap[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_lvl[i]) begin
                if (m_low[i] != 0) m_gap[i] <= m_low[i];
                m_low[i] <= 0;
            end else begin
                m_low[i] <= m_low[i] + 1;
            end
            case (m_st[i])
                0: if (m_lvl[i] && !m_stall[i]) begin
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= C_BUSY;
                    m_st[i]   <= 1;
                end
                1: begin
                    if (m_cnt[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_dout[i] <= rdata(m_addr[i]);
                        m_st[i]   <= 2;
                    end
                    m_cnt[i] <= m_cnt[i] - 1;
                end
                default: if (!m_lvl[i]) m_st[i] <= 0;
            endcase
        end
    end

    // Ack logging, sampled on the falling edge.
    int          ack_a0 = 0;
    int          ack_b0 = 0;
    int          rr_n   = 0;
    logic [15:0] rr_order = '0;

    always @(negedge clk) begin
        if (if0.a_ack) ack_a0 = ack_a0 + 1;
        if (if0.b_ack) ack_b0 = ack_b0 + 1;
        if ((if1.a_ack || if1.b_ack) && rr_n < 16) begin
            rr_order[rr_n] = if1.b_ack;
            rr_n = rr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack0(input bit port_b, input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!(port_b ? if0.b_ack : if0.a_ack) && cycles < limit);
    endtask

    int  cyc;
    int  snap;
    bit  ok_rd;
    bit  ok_addr;

    initial begin
        reset_n = 1'b0;
        if0.a_req = 0; if0.a_we = 0; if0.a_word = 0; if0.a_addr = '0; if0.a_din = '0;
        if0.b_req = 0; if0.b_we = 0; if0.b_word = 0; if0.b_addr = '0; if0.b_din = '0;
        if1.a_req = 0; if1.a_we = 0; if1.a_word = 0; if1.a_addr = '0; if1.a_din = '0;
        if1.b_req = 0; if1.b_we = 0; if1.b_word = 0; if1.b_addr = '0; if1.b_din = '0;
        repeat (3) step();

        check("rst_mem_rdwr", 32'({if0.mem_rd, if0.mem_wr, if0.mem_word}), 32'h0);
        check("rst_mem_addr", 32'(if0.mem_addr), 32'h0);
        check("rst_mem_din",  32'(if0.mem_din), 32'h0);
        check("rst_acks",     32'({if0.a_ack, if0.b_ack}), 32'h0);
        check("rst_douts",    {if0.a_dout, if0.b_dout}, 32'h0);
        reset_n = 1'b1;
        step();

        // Single read on port A
        if0.a_req = 1; if0.a_we = 0; if0.a_word = 1; if0.a_addr = 25'h100;
        step();
        check("rd_lat_rd_low", 32'(if0.mem_rd), 32'h0);
        step();
        check("rd_lat_rd_high", 32'(if0.mem_rd), 32'h1);
        check("rd_mem_addr", 32'(if0.mem_addr), 32'h100);
        wait_ack0(1'b0, 50, cyc);
        if0.a_req = 0;
        check("rd_req_to_ack", 32'(cyc + 2), 32'd9);
        check("rd_a_dout", 32'(if0.a_dout), 32'hBEEF);
        step();
        check("rd_ack_one_pulse", 32'(if0.a_ack), 32'h0);
        check("rd_ack_counts", 32'({ack_a0[7:0], ack_b0[7:0]}), 32'h0100);

        // Collision with fixed priority
        if0.a_addr = 25'h10; if0.b_addr = 25'h20; if0.b_we = 0; if0.b_word = 1;
        if0.a_req = 1; if0.b_req = 1;
        cyc = 0;
        do begin step(); cyc++; end while (!(if0.a_ack || if0.b_ack) && cyc < 50);
        check("fix_first_grant", 32'({if0.a_ack, if0.b_ack}), 32'h2);
        check("fix_a_dout", 32'(if0.a_dout), 32'hC3D3);
        if0.a_req = 0;
        wait_ack0(1'b1, 50, cyc);
        if0.b_req = 0;
        check("fix_b_ack", 32'(if0.b_ack), 32'h1);
        check("fix_b_dout", 32'(if0.b_dout), 32'hC3E3);
        check("fix_gap_ge2", 32'(m_gap[0] >= 2), 32'h1);
        step();

        // Init stall: controller ignores the edge for 200 cycles
        m_stall[0] = 1'b1;
        snap = ack_a0;
        if0.a_addr = 25'h1234; if0.a_req = 1;
        repeat (2) step();
        ok_rd = 1; ok_addr = 1;
        repeat (200) begin
            step();
            if (if0.mem_rd !== 1'b1) ok_rd = 0;
            if (if0.mem_addr !== 25'h1234) ok_addr = 0;
        end
        check("stall_rd_held", 32'(ok_rd), 32'h1);
        check("stall_addr_held", 32'(ok_addr), 32'h1);
        check("stall_no_ack", 32'(ack_a0 - snap), 32'h0);
        m_stall[0] = 1'b0;
        wait_ack0(1'b0, 50, cyc);
        if0.a_req = 0;
        check("stall_ack", 32'(if0.a_ack), 32'h1);
        check("stall_a_dout", 32'(if0.a_dout), 32'hD1F7);
        step();

        // Byte write on port B
        if0.b_we = 1; if0.b_word = 0; if0.b_addr = 25'h3; if0.b_din = 16'h00A5; if0.b_req = 1;
        cyc = 0;
        do begin step(); cyc++; end while (!if0.mem_wr && cyc < 20);
        check("wr_mem_flags", 32'({if0.mem_wr, if0.mem_rd, if0.mem_word}), 32'h4);
        check("wr_mem_addr", 32'(if0.mem_addr), 32'h3);
        check("wr_mem_din", 32'(if0.mem_din), 32'h00A5);
        ok_addr = 1;
        cyc = 0;
        while (!if0.b_ack && cyc < 50) begin
            if (if0.mem_wr !== 1'b1 || if0.mem_word !== 1'b0 ||
                if0.mem_addr !== 25'h3 || if0.mem_din !== 16'h00A5) ok_addr = 0;
            step();
            cyc++;
        end
        if0.b_req = 0;
        check("wr_stable", 32'(ok_addr), 32'h1);
        check("wr_b_ack", 32'(if0.b_ack), 32'h1);
        check("wr_douts_kept", {if0.a_dout, if0.b_dout}, 32'hD1F7C3E3);
        step();

        // Reset in the middle of an access
        if0.b_we = 0;
        snap = ack_a0;
        if0.a_addr = 25'h40; if0.a_req = 1;
        cyc = 0;
        do begin step(); cyc++; end while (!m_busy[0] && cyc < 20);
        step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd_low", 32'({if0.mem_rd, if0.mem_wr}), 32'h0);
        check("mid_rst_acks", 32'({if0.a_ack, if0.b_ack}), 32'h0);
        check("mid_rst_a_dout", 32'(if0.a_dout), 32'h0);
        if0.a_req = 0;
        repeat (2) step();
        reset_n = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (m_st[0] != 0 && cyc < 20);
        check("mid_rst_no_ack", 32'(ack_a0 - snap), 32'h0);
        if0.a_addr = 25'h44; if0.a_req = 1;
        wait_ack0(1'b0, 50, cyc);
        if0.a_req = 0;
        check("post_rst_ack", 32'(if0.a_ack), 32'h1);
        check("post_rst_a_dout", 32'(if0.a_dout), 32'hC387);
        step();

        // Round robin: both ports request continuously
        if1.a_addr = 25'h50; if1.b_addr = 25'h60;
        if1.a_req = 1; if1.b_req = 1;
        cyc = 0;
        while (rr_n < 6 && cyc < 200) begin step(); cyc++; end
        if1.a_req = 0; if1.b_req = 0;
        check("rr_count", 32'(rr_n), 32'd6);
        check("rr_order", 32'(rr_order[5:0]), 32'h2A);
        check("rr_a_dout", 32'(if1.a_dout), 32'hC393);
        check("rr_b_dout", 32'(if1.b_dout), 32'hC3A3);
        repeat (20) step();
        check("rr_no_extra", 32'(rr_n), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
